// File: rtl/lms_coeff_engine_pkg.sv
// lms_pkg: shared types for the LMS coefficient update engine.
//   sample_t / err_t / acc_t / coeff_t  default-width data types
//   lms_state_t                         engine FSM states
//   sat_add()                           saturating accumulate at the default widths
// Parameterised instances with other widths use the width-generic datapath in
// lms_lane. sat_add is the reference form of that datapath at the default sizes.
package lms_pkg;

    localparam int LMS_SAMPLE_W = 16;
    localparam int LMS_ERR_W    = 16;
    localparam int LMS_ACC_W    = 35;
    localparam int LMS_COEFF_W  = 10;

    typedef logic signed [LMS_SAMPLE_W-1:0] sample_t;
    typedef logic signed [LMS_ERR_W-1:0]    err_t;
    typedef logic signed [LMS_ACC_W-1:0]    acc_t;
    typedef logic signed [LMS_ACC_W:0]      acc_wide_t;
    typedef logic signed [LMS_COEFF_W-1:0]  coeff_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } lms_state_t;

    // One guard bit is enough: overflow shows as the two top bits disagreeing.
    function automatic acc_t sat_add(input acc_t acc, input acc_wide_t delta);
        acc_wide_t sum;
        sum = acc_wide_t'(acc) + delta;
        if (sum[LMS_ACC_W] != sum[LMS_ACC_W-1])
            return {sum[LMS_ACC_W], {(LMS_ACC_W-1){~sum[LMS_ACC_W]}}};
        return sum[LMS_ACC_W-1:0];
    endfunction

endpackage

// File: rtl/lms_coeff_engine_lane.sv
// lms_lane: one quantise-multiply-(leak)-saturate-accumulate datapath (combinational).
//   err_i     latched error sample
//   sample_i  reference sample for this tap
//   acc_i     current accumulator for this tap
//   acc_o     saturated next accumulator value
// Optional: LMS_LEAKAGE_EN adds acc >>> LEAK_SHIFT leakage before the add.
module lms_lane #(
    parameter int ERR_W      = 16,
    parameter int SAMPLE_W   = 16,
    parameter int MU_SHIFT   = 13,
`ifdef LMS_LEAKAGE_EN
    parameter int LEAK_SHIFT = 12,
`endif
    parameter int ACC_W      = 35
) (
    input  logic signed [ERR_W-1:0]    err_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic signed [ACC_W-1:0]    acc_i,
    output logic signed [ACC_W-1:0]    acc_o
);
    localparam int QW = ERR_W - MU_SHIFT;
    localparam int PW = QW + SAMPLE_W;

    logic signed [QW-1:0]  q;
    logic signed [PW-1:0]  prod;
    logic signed [ACC_W:0] acc_x, delta, sum;
    logic                  ovf;

    // After the arithmetic shift only QW bits carry information; the rest are sign copies.
    assign q     = QW'(err_i >>> MU_SHIFT);
    assign prod  = PW'(q) * PW'(sample_i);
    assign delta = (ACC_W+1)'(prod);
    assign acc_x = (ACC_W+1)'(acc_i);

`ifdef LMS_LEAKAGE_EN
    logic signed [ACC_W-1:0] leak;
    logic signed [ACC_W:0]   leak_x;
    assign leak   = acc_i >>> LEAK_SHIFT;
    assign leak_x = (ACC_W+1)'(leak);
    assign sum    = acc_x - leak_x + delta;
`else
    assign sum    = acc_x + delta;
`endif

    assign ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_o = ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];

endmodule

// File: rtl/lms_coeff_engine.sv
// lms_coeff_engine: time-multiplexed LMS weight update, LANES taps per cycle.
//   clk_in / rst_in       clock, synchronous active-high reset
//   ready_in              start-of-pass strobe, honoured only in IDLE
//   error_in, offset_in   latched at pass start
//   sample_addr_out       per-lane ring read address (0 outside RUN)
//   sample_data_in        per-lane ring read data, one cycle after the address
//   coeffs_out            coefficient set, reloaded atomically at pass end
//   busy_out, done        pass in progress / one-cycle completion pulse
// Optional: `define LMS_LEAKAGE_EN for leaky LMS (uses LEAK_SHIFT).
module lms_coeff_engine
    import lms_pkg::*;
#(
    parameter int     TAPS       = 64,
    parameter int     LANES      = 4,
    parameter int     SAMPLE_W   = 16,
    parameter int     ERR_W      = 16,
    parameter int     MU_SHIFT   = 13,
    parameter int     ACC_W      = 35,
    parameter int     COEFF_W    = 10,
    parameter longint INIT_ACC   = 64'sd67108864,
    parameter int     LEAK_SHIFT = 12
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               ready_in,
    input  logic signed [ERR_W-1:0]            error_in,
    input  logic [$clog2(TAPS)-1:0]            offset_in,
    output logic [LANES-1:0][$clog2(TAPS)-1:0] sample_addr_out,
    input  logic [LANES-1:0][SAMPLE_W-1:0]     sample_data_in,
    output logic [TAPS-1:0][COEFF_W-1:0]       coeffs_out,
    output logic                               busy_out,
    output logic                               done
);
    localparam int G  = TAPS / LANES;
    localparam int AW = $clog2(TAPS);
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [ACC_W-1:0]   ACC_RST   = ACC_W'(INIT_ACC);
    localparam logic [COEFF_W-1:0] COEFF_RST = ACC_RST[ACC_W-1 -: COEFF_W];

    lms_state_t               state_q, state_d;
    logic [GW-1:0]            grp_q, grp_d, upd_grp_q;
    logic                     upd_vld_q;
    logic [ERR_W-1:0]         err_q, err_d;
    logic [AW-1:0]            off_q, off_d;
    logic [TAPS-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [TAPS-1:0][COEFF_W-1:0] coeffs_q;
    logic                     done_q;
    logic [LANES-1:0][AW-1:0]    iss_k, upd_k;
    logic [LANES-1:0][ACC_W-1:0] lane_acc;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        err_d   = err_q;
        off_d   = off_q;
        case (state_q)
            IDLE: if (ready_in) begin
                state_d = RUN;
                grp_d   = '0;
                err_d   = error_in;
                off_d   = offset_in;
            end
            RUN: begin
                grp_d = grp_q + GW'(1);
                if (grp_q == GW'(G-1)) state_d = LAST;
            end
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign iss_k[l] = AW'(int'(grp_q) * LANES + l);
        assign upd_k[l] = AW'(int'(upd_grp_q) * LANES + l);
        // Ring index wraps naturally in AW bits.
        assign sample_addr_out[l] = (state_q == RUN) ? off_q - iss_k[l] : '0;

        lms_lane #(
            .ERR_W(ERR_W), .SAMPLE_W(SAMPLE_W), .MU_SHIFT(MU_SHIFT),
`ifdef LMS_LEAKAGE_EN
            .LEAK_SHIFT(LEAK_SHIFT),
`endif
            .ACC_W(ACC_W)
        ) u_lane (
            .err_i   (err_q),
            .sample_i(sample_data_in[l]),
            .acc_i   (acc_q[upd_k[l]]),
            .acc_o   (lane_acc[l])
        );
    end

    always_comb begin
        acc_d = acc_q;
        if (upd_vld_q)
            for (int l = 0; l < LANES; l++) acc_d[upd_k[l]] = lane_acc[l];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            grp_q     <= '0;
            upd_grp_q <= '0;
            upd_vld_q <= 1'b0;
            err_q     <= '0;
            off_q     <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                acc_q[k]    <= ACC_RST;
                coeffs_q[k] <= COEFF_RST;
            end
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            err_q     <= err_d;
            off_q     <= off_d;
            upd_vld_q <= (state_q == RUN);
            upd_grp_q <= grp_q;
            acc_q     <= acc_d;
            done_q    <= (state_q == LAST);
            // The last group lands on this same edge, so load from acc_d, not acc_q.
            if (state_q == LAST)
                for (int k = 0; k < TAPS; k++) coeffs_q[k] <= acc_d[k][ACC_W-1 -: COEFF_W];
        end
    end

    assign coeffs_out = coeffs_q;
    assign busy_out   = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_lms_coeff_engine.sv
module tb_lms_coeff_engine;

    logic              clk_in = 1'b0;
    logic              rst_in, ready_in;
    logic signed [15:0] error_in;
    logic [5:0]        offset_in;
    logic [3:0][5:0]   addr1, addr2;
    logic [3:0][15:0]  sd1, sd2;
    logic [63:0][9:0]  coeffs1, coeffs2;
    logic              busy1, busy2, done1, done2;
    logic [15:0]       ring [64];

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    // Default-width engine.
    lms_coeff_engine u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in), .error_in(error_in),
        .offset_in(offset_in), .sample_addr_out(addr1), .sample_data_in(sd1),
        .coeffs_out(coeffs1), .busy_out(busy1), .done(done1)
    );

    // Narrow accumulator to reach the saturation rails quickly.
    lms_coeff_engine #(.ACC_W(20), .INIT_ACC(0)) u_dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in), .error_in(error_in),
        .offset_in(offset_in), .sample_addr_out(addr2), .sample_data_in(sd2),
        .coeffs_out(coeffs2), .busy_out(busy2), .done(done2)
    );

    // Sample ring read port: data one cycle after address.
    always @(posedge clk_in) begin
        for (int l = 0; l < 4; l++) begin
            sd1[l] <= ring[addr1[l]];
            sd2[l] <= ring[addr2[l]];
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done1 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (done1 !== 1'b1) chk("pass_timeout", 0, 1);
    endtask

    task automatic run_pass();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        wait_done();
    endtask

    task automatic chk_all(input int which, input longint exp_coeff, input longint exp_acc);
        for (int k = 0; k < 64; k++) begin
            if (which == 1) begin
                chk($sformatf("coeff1[%0d]", k), $signed(coeffs1[k]), exp_coeff);
                chk($sformatf("acc1[%0d]", k), $signed(u_dut1.acc_q[k]), exp_acc);
            end else begin
                chk($sformatf("coeff2[%0d]", k), $signed(coeffs2[k]), exp_coeff);
                chk($sformatf("acc2[%0d]", k), $signed(u_dut2.acc_q[k]), exp_acc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ring[i] = 16'h7FFF;
        rst_in = 1'b1; ready_in = 1'b0; error_in = '0; offset_in = '0;

        // Reset state
        tick(); tick();
        chk_all(1, 2, 67108864);
        chk_all(2, 0, 0);
        chk("rst_done", done1, 0);
        chk("rst_busy", busy1, 0);
        for (int l = 0; l < 4; l++) chk($sformatf("rst_addr[%0d]", l), addr1[l], 0);
        rst_in = 1'b0;
        tick();

        // Latency / handshake, zero error so weights stay put
        ready_in = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            tick();
            ready_in = (c == 5 || c == 10 || c == 18);
            chk($sformatf("busy@%0d", c), busy1,
                ((c >= 1 && c <= 17) || (c >= 19 && c <= 35)) ? 1 : 0);
            chk($sformatf("done@%0d", c), done1, (c == 18 || c == 36) ? 1 : 0);
        end
        ready_in = 1'b0;
        chk("addr_idle", addr1[2], 0);

        // Address wrap with offset 3
        offset_in = 6'd3;
        ready_in  = 1'b1;
        tick();
        ready_in  = 1'b0;
        chk("g0_l0", addr1[0], 3);
        chk("g0_l1", addr1[1], 2);
        chk("g0_l2", addr1[2], 1);
        chk("g0_l3", addr1[3], 0);
        tick();
        chk("g1_l0", addr1[0], 63);
        chk("g1_l1", addr1[1], 62);
        chk("g1_l2", addr1[2], 61);
        chk("g1_l3", addr1[3], 60);
        wait_done();
        chk_all(1, 2, 67108864);

        // Convergence: q = 3, sample 32767 -> +98301 per pass
        error_in = 16'sh6000;
        for (int p = 0; p < 8; p++) run_pass();
        chk_all(2, 511, 524287);
        chk("acc1_8pass", $signed(u_dut1.acc_q[17]), 67108864 + 8 * 98301);
        for (int p = 8; p < 512; p++) run_pass();
        chk_all(1, 3, 117438976);
        chk_all(2, 511, 524287);

        // Negative error: q = -3
        error_in = 16'shA000;
        for (int p = 0; p < 12; p++) run_pass();
        chk_all(2, -512, -524288);
        chk("acc1_neg", $signed(u_dut1.acc_q[40]), 117438976 - 12 * 98301);
        chk("coeff1_neg", $signed(coeffs1[40]), 3);

        // Reset mid-pass at cycle 6
        tick();
        error_in = 16'sh6000;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("mid_rst_busy", busy1, 0);
        for (int c = 0; c < 25; c++) begin
            chk($sformatf("mid_rst_done@%0d", c), done1, 0);
            tick();
        end
        chk_all(1, 2, 67108864);
        chk_all(2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
